// File: rtl/snake_body.sv
// rtl/snake_body.sv - snake body registers: segments, length, direction, wall/self collision
module snake_body #(
  parameter int max_len         = 16,
  parameter int num_len         = 10,
  parameter int max_len_bit_len = 4,
  parameter int width           = 32,
  parameter int height          = 24,
  parameter int init_pos        = 400,
  parameter int init_len        = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         step,
  input  logic                         dir_valid,
  input  logic [1:0]                   dir,
  input  logic                         grow,
  output logic [max_len*num_len-1:0]   snake,
  output logic [num_len-1:0]           snake_head,
  output logic [max_len_bit_len:0]     length,
  output logic                         alive,
  output logic                         dead
);

  localparam int LW = max_len_bit_len + 1;

  // Unused slots hold all-ones, which lies outside the playfield
  localparam logic [num_len-1:0] SENT      = {num_len{1'b1}};
  localparam logic [num_len-1:0] W_C       = num_len'(width);
  localparam logic [num_len-1:0] X_MAX     = num_len'(width - 1);
  localparam logic [num_len-1:0] Y_MAX     = num_len'(height - 1);
  localparam logic [num_len-1:0] ONE       = num_len'(1);
  localparam logic [LW-1:0]      INIT_LEN  = LW'(init_len);
  localparam logic [LW-1:0]      MAX_LEN_C = LW'(max_len);

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_RIGHT = 2'd1;
  localparam logic [1:0] D_DOWN  = 2'd2;
  localparam logic [1:0] D_LEFT  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  state_t             r_state;
  logic [num_len-1:0] r_seg [max_len];
  logic [LW-1:0]      r_len;
  logic [1:0]         r_cur_dir;
  logic [1:0]         r_next_dir;
  logic               r_grow_pend;

  logic               w_req_ok;
  logic [1:0]         w_next_dir;
  logic               w_grow;
  logic [num_len-1:0] w_x;
  logic [num_len-1:0] w_y;
  logic [num_len-1:0] w_new_head;
  logic               w_wall;
  logic               w_self;
  logic [LW-1:0]      w_new_len;
  int                 w_len_i;
  int                 w_new_len_i;

  // Contents of slot i after reset or start
  function automatic logic [num_len-1:0] init_seg(input int i);
    if (i < init_len) return num_len'(init_pos - i);
    else return SENT;
  endfunction

  // Direction request filter (reverse of the current heading is dropped) and grow merge
  always_comb begin
    w_req_ok   = dir_valid && (dir != (r_cur_dir ^ 2'd2));
    w_next_dir = w_req_ok ? dir : r_next_dir;
    w_grow     = grow || r_grow_pend;
  end

  // Candidate head and wall test, judged on x/y so no wrap-around can sneak in
  always_comb begin
    w_x        = r_seg[0] % W_C;
    w_y        = r_seg[0] / W_C;
    w_new_head = r_seg[0];
    w_wall     = 1'b0;
    case (w_next_dir)
      D_UP:    begin w_new_head = r_seg[0] - W_C; w_wall = (w_y == '0);    end
      D_RIGHT: begin w_new_head = r_seg[0] + ONE; w_wall = (w_x == X_MAX); end
      D_DOWN:  begin w_new_head = r_seg[0] + W_C; w_wall = (w_y == Y_MAX); end
      default: begin w_new_head = r_seg[0] - ONE; w_wall = (w_x == '0);    end
    endcase
  end

  // Self collision against live body; the tail is skipped when it moves away this step
  always_comb begin
    w_len_i     = int'(r_len);
    w_new_len   = (w_grow && (r_len < MAX_LEN_C)) ? r_len + LW'(1) : r_len;
    w_new_len_i = int'(w_new_len);
    w_self      = 1'b0;
    for (int i = 1; i < max_len; i++) begin
      if ((i < w_len_i) && !((i == w_len_i - 1) && !w_grow) && (r_seg[i] == w_new_head))
        w_self = 1'b1;
    end
  end

  // Game state, body shift and direction/grow bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= INIT_LEN;
      r_cur_dir   <= D_RIGHT;
      r_next_dir  <= D_RIGHT;
      r_grow_pend <= 1'b0;
      for (int i = 0; i < max_len; i++) r_seg[i] <= init_seg(i);
    end else if (start) begin
      r_state     <= S_RUN;
      r_len       <= INIT_LEN;
      r_cur_dir   <= D_RIGHT;
      r_next_dir  <= D_RIGHT;
      r_grow_pend <= 1'b0;
      for (int i = 0; i < max_len; i++) r_seg[i] <= init_seg(i);
    end else begin
      r_next_dir <= w_next_dir;
      if (step && (r_state == S_RUN)) begin
        r_cur_dir   <= w_next_dir;
        r_grow_pend <= 1'b0;
        if (w_wall || w_self) begin
          r_state <= S_DEAD;
        end else begin
          r_len    <= w_new_len;
          r_seg[0] <= w_new_head;
          for (int i = 1; i < max_len; i++)
            r_seg[i] <= (i < w_new_len_i) ? r_seg[i-1] : SENT;
        end
      end else if (grow) begin
        r_grow_pend <= 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < max_len; g++) begin : g_pack
      assign snake[g*num_len +: num_len] = r_seg[g];
    end
  endgenerate

  assign snake_head = r_seg[0];
  assign length     = r_len;
  assign alive      = (r_state == S_RUN);
  assign dead       = (r_state == S_DEAD);

endmodule

// File: tb/tb_snake_body.sv
// tb/tb_snake_body.sv - randomized and directed bench for snake_body against a coordinate model
module tb_snake_body;

  localparam int ML = 16;
  localparam int NL = 10;
  localparam int VW = ML * NL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          dir_valid = 1'b0;
  logic [1:0]    dir = 2'd0;
  logic          grow = 1'b0;
  logic [VW-1:0] snake;
  logic [NL-1:0] snake_head;
  logic [4:0]    length;
  logic          alive;
  logic          dead;

  int total = 0;
  int bad = 0;

  // model: body as list of cell numbers, head first
  int q[$];
  int m_cur;
  int m_next;
  bit m_pend;
  int m_state;   // 0 idle, 1 run, 2 dead

  snake_body dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step),
    .dir_valid(dir_valid), .dir(dir), .grow(grow),
    .snake(snake), .snake_head(snake_head), .length(length),
    .alive(alive), .dead(dead)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reload();
    q = {400, 399, 398};
    m_cur = 1;
    m_next = 1;
    m_pend = 0;
  endtask

  task automatic m_cycle(input bit st, input bit sp, input bit dv, input int d, input bit gr);
    int hx, hy, nx, ny, nh, dd;
    bit g, wall, self_hit;
    if (st) begin
      m_reload();
      m_state = 1;
      return;
    end
    if (dv && d != (m_cur + 2) % 4) m_next = d;
    if (sp && m_state == 1) begin
      dd = m_next;
      m_cur = dd;
      g = gr || m_pend;
      m_pend = 0;
      hx = q[0] % 32;
      hy = q[0] / 32;
      nx = hx; ny = hy;
      wall = 0;
      if (dd == 0) begin wall = (hy == 0);  ny = hy - 1; end
      if (dd == 1) begin wall = (hx == 31); nx = hx + 1; end
      if (dd == 2) begin wall = (hy == 23); ny = hy + 1; end
      if (dd == 3) begin wall = (hx == 0);  nx = hx - 1; end
      nh = ny * 32 + nx;
      self_hit = 0;
      for (int i = 1; i < q.size(); i++)
        if (!(i == q.size() - 1 && !g) && q[i] == nh) self_hit = 1;
      if (wall || self_hit) begin
        m_state = 2;
      end else begin
        q.push_front(nh);
        if (!g || q.size() > ML) void'(q.pop_back());
      end
    end else if (gr) begin
      m_pend = 1;
    end
  endtask

  task automatic check_model(input string tag);
    logic [VW-1:0] exp;
    for (int i = 0; i < ML; i++)
      exp[i*NL +: NL] = (i < q.size()) ? NL'(q[i]) : {NL{1'b1}};
    chk({tag, ".snake"}, snake, exp);
    chk({tag, ".head"}, VW'(snake_head), VW'(q[0]));
    chk({tag, ".length"}, VW'(length), VW'(q.size()));
    chk({tag, ".alive"}, VW'(alive), VW'(m_state == 1));
    chk({tag, ".dead"}, VW'(dead), VW'(m_state == 2));
  endtask

  task automatic cyc(input string tag, input bit st, input bit sp, input bit dv, input int d, input bit gr);
    start = st; step = sp; dir_valid = dv; dir = 2'(d); grow = gr;
    @(posedge clk);
    m_cycle(st, sp, dv, d, gr);
    #1;
    start = 0; step = 0; dir_valid = 0; grow = 0;
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    bit st, sp, dv, gr;
    int d;
    logic [NL-1:0] seg3;

    m_reload();
    m_state = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_model("reset");

    cyc("start", 1, 0, 0, 0, 0);
    chk("start_head400", VW'(snake_head), VW'(400));

    cyc("right1", 0, 1, 0, 0, 0);
    cyc("right2", 0, 1, 0, 0, 0);
    chk("right_head402", VW'(snake_head), VW'(402));
    seg3 = snake[3*NL +: NL];
    chk("right_seg3_sentinel", VW'(seg3), VW'(1023));

    cyc("restart1", 1, 0, 0, 0, 0);
    cyc("reverse_dropped", 0, 1, 1, 3, 0);
    chk("reverse_head401", VW'(snake_head), VW'(401));
    cyc("turn_up", 0, 1, 1, 0, 0);
    chk("up_head369", VW'(snake_head), VW'(369));

    cyc("restart2", 1, 0, 0, 0, 0);
    cyc("grow_step", 0, 1, 0, 0, 1);
    chk("grow_len4", VW'(length), VW'(4));
    cyc("plain_after_grow", 0, 1, 0, 0, 0);
    chk("grow_len_kept4", VW'(length), VW'(4));

    cyc("restart3", 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc("run_to_wall", 0, 1, 0, 0, 0);
    chk("wall_head415", VW'(snake_head), VW'(415));
    cyc("wall_hit", 0, 1, 0, 0, 0);
    chk("wall_dead", VW'(dead), VW'(1));
    chk("wall_head_frozen", VW'(snake_head), VW'(415));
    cyc("step_in_dead", 0, 1, 0, 0, 0);

    cyc("restart4", 1, 0, 0, 0, 0);
    cyc("grow_a", 0, 0, 0, 0, 1);
    cyc("grow_a_twice", 0, 1, 0, 0, 1);
    cyc("grow_b", 0, 1, 0, 0, 1);
    chk("uturn_len5", VW'(length), VW'(5));
    cyc("uturn_up", 0, 1, 1, 0, 0);
    cyc("uturn_left", 0, 1, 1, 3, 0);
    cyc("uturn_down", 0, 1, 1, 2, 0);
    chk("self_dead", VW'(dead), VW'(1));
    cyc("restart5", 1, 0, 0, 0, 0);
    chk("restart_head400", VW'(snake_head), VW'(400));
    chk("restart_alive", VW'(alive), VW'(1));

    for (int n = 0; n < 600; n++) begin
      st = (m_state != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 79) == 0);
      sp = $urandom_range(0, 1);
      dv = ($urandom_range(0, 2) == 0);
      d  = $urandom_range(0, 3);
      gr = ($urandom_range(0, 4) == 0);
      cyc("random", st, sp, dv, d, gr);
    end

    // asynchronous reset landing between clock edges
    #2;
    rst_n = 1'b0;
    m_reload();
    m_state = 0;
    #1;
    check_model("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_model("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
